// File: rtl/gpu_pkg.sv
// Shared opcode decode for the GP0 command receiver: range constants, framer
// states and the per-opcode packet length / kind lookup.
package gpu_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FIXED = 2'd1;
  localparam logic [1:0] ST_POLY  = 2'd2;
  localparam logic [1:0] ST_IMG   = 2'd3;

  localparam logic [1:0] K_FIXED = 2'd0;
  localparam logic [1:0] K_POLY  = 2'd1;
  localparam logic [1:0] K_IMG   = 2'd2;

  localparam logic [2:0] OPR_POLY = 3'b001;
  localparam logic [2:0] OPR_LINE = 3'b010;
  localparam logic [2:0] OPR_RECT = 3'b011;
  localparam logic [2:0] OPR_COPY = 3'b100;
  localparam logic [2:0] OPR_IMG  = 3'b101;
  localparam logic [2:0] OPR_RDBK = 3'b110;
  localparam logic [7:0] OP_FILL  = 8'h02;

  localparam logic [31:0] POLY_MASK = 32'hF000_F000;
  localparam logic [31:0] POLY_TERM = 32'h5000_5000;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] len;
  } gp0_len_t;

  // len counts the command word; poly/img lengths are resolved by the framer
  function automatic gp0_len_t gp0_len(input logic [7:0] op);
    gp0_len_t   r;
    logic [7:0] n;
    r.kind = K_FIXED;
    r.len  = 8'd1;
    n      = op[3] ? 8'd4 : 8'd3;
    if (op == OP_FILL) r.len = 8'd3;
    else begin
      case (op[7:5])
        OPR_POLY: r.len = 8'd1 + n * (8'd1 + {7'd0, op[2]}) + (op[4] ? n - 8'd1 : 8'd0);
        OPR_LINE: begin
          if (op[3]) begin
            r.kind = K_POLY;
            r.len  = 8'd0;
          end else r.len = op[4] ? 8'd4 : 8'd3;
        end
        OPR_RECT: r.len = 8'd2 + {7'd0, op[2]} + {7'd0, op[4:3] == 2'b00};
        OPR_COPY: r.len = 8'd4;
        OPR_IMG: begin
          r.kind = K_IMG;
          r.len  = 8'd3;
        end
        OPR_RDBK: r.len = 8'd3;
        default: ;
      endcase
    end
    return r;
  endfunction

  // halfword pixels packed two per word; zero size fields mean max extent
  function automatic logic [19:0] img_words(input logic [9:0] wf, input logic [8:0] hf);
    logic [10:0] w;
    logic [9:0]  h;
    logic [20:0] px;
    w  = (wf == '0) ? 11'd1024 : {1'b0, wf};
    h  = (hf == '0) ? 10'd512 : {1'b0, hf};
    px = 21'(w) * 21'(h);
    return 20'((px + 21'd1) >> 1);
  endfunction

endpackage

// File: rtl/gpu_sync_fifo.sv
// Show-ahead 32-bit synchronous FIFO with synchronous flush and occupancy count.
module gpu_sync_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [31:0]   wdata,
  input  logic          pop,
  output logic [31:0]   rdata,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end

  assign rdata = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/gpu_cmd_rx.sv
// GP0/GP1 command port receiver: buffers GP0 words, frames them into packets
// for the draw engine, and forwards GP1 control words as one-cycle pulses.
module gpu_cmd_rx
  import gpu_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   main_bus,
  input  logic          to_gp0,
  input  logic          to_gp1,
  output logic          fifo_full,
  output logic [CW-1:0] fifo_count,
  output logic          overflow,
  output logic [31:0]   gp1_word,
  output logic          gp1_valid,
  output logic [31:0]   pkt_word,
  output logic          pkt_valid,
  input  logic          pkt_ready,
  output logic          pkt_first,
  output logic          pkt_last,
  output logic [7:0]    pkt_opcode,
  output logic          busy
);

  logic [31:0]   head;
  logic          empty, full, flush, xfer, last;
  logic [CW-1:0] count;
  gp0_len_t      hinfo;

  logic [1:0]  state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  op_q, op_d;
  logic        shaded_q, shaded_d;
  logic [19:0] rem_q, rem_d;
  logic        ovf_q, ovf_d;
  logic [31:0] g1w_q, g1w_d;
  logic        g1v_q, g1v_d;

  // GP1 reset / reset-command-buffer opcodes also swallow a same-cycle GP0 word
  assign flush = to_gp1 & (main_bus[31:25] == 7'd0);

  gpu_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (to_gp0 & ~to_gp1),
    .wdata (main_bus),
    .pop   (xfer),
    .rdata (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  assign pkt_valid = ~empty;
  assign xfer      = pkt_valid & pkt_ready;
  assign hinfo     = gp0_len(head[31:24]);

  always_comb begin
    last = 1'b0;
    case (state_q)
      ST_IDLE:  last = (hinfo.kind == K_FIXED) && (hinfo.len == 8'd1);
      ST_FIXED: last = (idx_q == len_q - 8'd1);
      ST_POLY:  last = ((head & POLY_MASK) == POLY_TERM) &&
                       (shaded_q ? (idx_q >= 8'd4 && !idx_q[0]) : (idx_q >= 8'd3));
      default:  last = (idx_q == 8'd3) && (rem_q == 20'd1);
    endcase
  end

  // idx only needs parity past 4 for polylines, and tops out at 3 for image data
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_d    = len_q;
    op_d     = op_q;
    shaded_d = shaded_q;
    rem_d    = rem_q;
    if (xfer) begin
      case (state_q)
        ST_IDLE: begin
          op_d     = head[31:24];
          shaded_d = head[28];
          len_d    = hinfo.len;
          idx_d    = 8'd1;
          case (hinfo.kind)
            K_POLY:  state_d = ST_POLY;
            K_IMG:   state_d = ST_IMG;
            default: state_d = ST_FIXED;
          endcase
        end
        ST_FIXED: idx_d = idx_q + 8'd1;
        ST_POLY:  idx_d = (idx_q == 8'd5) ? 8'd4 : idx_q + 8'd1;
        default: begin
          if (idx_q == 8'd2)      rem_d = img_words(head[9:0], head[24:16]);
          else if (idx_q == 8'd3) rem_d = rem_q - 20'd1;
          if (idx_q != 8'd3)      idx_d = idx_q + 8'd1;
        end
      endcase
      if (last) begin
        state_d = ST_IDLE;
        idx_d   = 8'd0;
      end
    end
    if (flush) begin
      state_d = ST_IDLE;
      idx_d   = 8'd0;
      op_d    = 8'd0;
      rem_d   = 20'd0;
    end
  end

  assign ovf_d = flush ? 1'b0 : (ovf_q | (to_gp0 & (to_gp1 | full)));
  assign g1v_d = to_gp1;
  assign g1w_d = to_gp1 ? main_bus : g1w_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      len_q    <= '0;
      op_q     <= '0;
      shaded_q <= 1'b0;
      rem_q    <= '0;
      ovf_q    <= 1'b0;
      g1w_q    <= '0;
      g1v_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      op_q     <= op_d;
      shaded_q <= shaded_d;
      rem_q    <= rem_d;
      ovf_q    <= ovf_d;
      g1w_q    <= g1w_d;
      g1v_q    <= g1v_d;
    end
  end

  assign fifo_full  = full;
  assign fifo_count = count;
  assign overflow   = ovf_q;
  assign gp1_word   = g1w_q;
  assign gp1_valid  = g1v_q;
  assign pkt_word   = pkt_valid ? head : '0;
  assign pkt_first  = pkt_valid & (state_q == ST_IDLE);
  assign pkt_last   = pkt_valid & last;
  assign pkt_opcode = (state_q == ST_IDLE) ? pkt_word[31:24] : op_q;
  assign busy       = pkt_valid | (state_q != ST_IDLE);

endmodule

// File: tb/tb_gpu_cmd_rx.sv
// Randomized bench for gpu_cmd_rx against a queue-based packet model.
module tb_gpu_cmd_rx;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] main_bus = '0;
  logic        to_gp0 = 1'b0, to_gp1 = 1'b0, pkt_ready = 1'b0;
  logic        fifo_full, overflow, gp1_valid, pkt_valid, pkt_first, pkt_last, busy;
  logic [4:0]  fifo_count;
  logic [31:0] gp1_word, pkt_word;
  logic [7:0]  pkt_opcode;

  always #5 clk = ~clk;

  gpu_cmd_rx dut (
    .clk(clk), .rst_n(rst_n), .main_bus(main_bus), .to_gp0(to_gp0), .to_gp1(to_gp1),
    .fifo_full(fifo_full), .fifo_count(fifo_count), .overflow(overflow),
    .gp1_word(gp1_word), .gp1_valid(gp1_valid), .pkt_word(pkt_word), .pkt_valid(pkt_valid),
    .pkt_ready(pkt_ready), .pkt_first(pkt_first), .pkt_last(pkt_last),
    .pkt_opcode(pkt_opcode), .busy(busy)
  );

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  // model: FIFO contents plus position of the head word inside its packet
  logic [31:0] mq[$];
  logic [31:0] sq[$];
  int          m_idx = 0;
  logic [7:0]  m_op = '0;
  int          m_pay = 0;
  bit          m_ovf = 0, e_g1v = 0;
  logic [31:0] e_g1w = '0;

  function automatic bit is_poly(input int op);
    return op >= 'h40 && op <= 'h5F && (op & 8) != 0;
  endfunction

  function automatic bit is_img(input int op);
    return op >= 'hA0 && op <= 'hBF;
  endfunction

  function automatic int fix_len(input int op);
    int n;
    n = (op & 8) ? 4 : 3;
    if (op == 2) return 3;
    if (op >= 'h20 && op <= 'h3F) return 1 + n * (1 + ((op >> 2) & 1)) + ((op & 'h10) ? n - 1 : 0);
    if (op >= 'h40 && op <= 'h5F) return (op & 'h10) ? 4 : 3;
    if (op >= 'h60 && op <= 'h7F) return 2 + ((op >> 2) & 1) + (((op & 'h18) == 0) ? 1 : 0);
    if (op >= 'h80 && op <= 'h9F) return 4;
    if (op >= 'hC0 && op <= 'hDF) return 3;
    return 1;
  endfunction

  function automatic int img_pay(input logic [31:0] s);
    int w, h;
    w = int'(s[9:0]);
    h = int'(s[24:16]);
    if (w == 0) w = 1024;
    if (h == 0) h = 512;
    return (w * h + 1) / 2;
  endfunction

  function automatic bit exp_last(input logic [31:0] w);
    int op;
    op = (m_idx == 0) ? int'(w[31:24]) : int'(m_op);
    if (is_poly(op))
      return (w & 32'hF000F000) == 32'h50005000 &&
             ((op & 'h10) ? (m_idx >= 4 && m_idx % 2 == 0) : m_idx >= 3);
    if (is_img(op)) return m_idx >= 3 && m_idx == 2 + m_pay;
    return m_idx == fix_len(op) - 1;
  endfunction

  task automatic check_now();
    chk("pkt_valid", pkt_valid, mq.size() > 0);
    chk("fifo_count", fifo_count, mq.size());
    chk("fifo_full", fifo_full, mq.size() == 16);
    chk("overflow", overflow, m_ovf);
    chk("busy", busy, mq.size() > 0 || m_idx != 0);
    chk("gp1_valid", gp1_valid, e_g1v);
    if (e_g1v) chk("gp1_word", gp1_word, e_g1w);
    if (mq.size() > 0) begin
      chk("pkt_word", pkt_word, mq[0]);
      chk("pkt_first", pkt_first, m_idx == 0);
      chk("pkt_last", pkt_last, exp_last(mq[0]));
      chk("pkt_opcode", pkt_opcode, (m_idx == 0) ? mq[0][31:24] : m_op);
    end
  endtask

  task automatic model_step();
    logic [31:0] w;
    bit lst, full0, fl;
    full0 = mq.size() == 16;
    fl    = to_gp1 && main_bus[31:25] == 7'd0;
    if (mq.size() > 0 && pkt_ready) begin
      w   = mq.pop_front();
      lst = exp_last(w);
      if (m_idx == 0) m_op = w[31:24];
      if (is_img(m_op) && m_idx == 2) m_pay = img_pay(w);
      m_idx = lst ? 0 : m_idx + 1;
    end
    e_g1v = to_gp1;
    if (to_gp1) e_g1w = main_bus;
    if (fl) begin
      mq.delete();
      m_idx = 0;
      m_ovf = 0;
    end else if (to_gp0) begin
      if (to_gp1 || full0) m_ovf = 1;
      else mq.push_back(main_bus);
    end
  endtask

  task automatic cyc(input bit g0, input bit g1, input logic [31:0] bus, input bit rdy);
    to_gp0 = g0; to_gp1 = g1; main_bus = bus; pkt_ready = rdy;
    @(negedge clk);
    check_now();
    model_step();
    @(posedge clk);
    #1;
    to_gp0 = 0; to_gp1 = 0; pkt_ready = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    #2;
    chk("rst_pkt_valid", pkt_valid, 0);
    chk("rst_pkt_first", pkt_first, 0);
    chk("rst_pkt_last", pkt_last, 0);
    chk("rst_pkt_opcode", pkt_opcode, 0);
    chk("rst_pkt_word", pkt_word, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_fifo_full", fifo_full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gp1_valid", gp1_valid, 0);
    chk("rst_gp1_word", gp1_word, 0);
    mq.delete(); sq.delete();
    m_idx = 0; m_op = '0; m_pay = 0; m_ovf = 0; e_g1v = 0; e_g1w = '0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_stim(input bit rnd_rdy);
    int budget;
    budget = 20000;
    while ((sq.size() > 0 || mq.size() > 0 || m_idx != 0) && budget > 0) begin
      bit g0, rdy;
      g0  = sq.size() > 0 && mq.size() < 16 && $urandom_range(0, 4) != 0;
      rdy = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (g0) begin
        cyc(1, 0, sq[0], rdy);
        void'(sq.pop_front());
      end else cyc(0, 0, $urandom, rdy);
      budget--;
    end
    chk("drained", sq.size() + mq.size() + m_idx, 0);
  endtask

  task automatic gen_pkt(input logic [7:0] op);
    logic [31:0] s;
    int k;
    sq.push_back({op, 24'($urandom)});
    if (is_poly(op)) begin
      k = op[4] ? 3 + 2 * $urandom_range(0, 2) : 2 + $urandom_range(0, 3);
      repeat (k) sq.push_back($urandom & 32'h0FFF0FFF);
      sq.push_back(($urandom & 32'h0FFF0FFF) | 32'h50005000);
    end else if (is_img(op)) begin
      sq.push_back($urandom);
      s = {7'd0, 9'($urandom_range(1, 3)), 6'd0, 10'($urandom_range(1, 6))};
      sq.push_back(s);
      repeat (img_pay(s)) sq.push_back($urandom);
    end else repeat (fix_len(op) - 1) sq.push_back($urandom);
  endtask

  initial begin
    do_reset();

    // single-word packet, always-ready consumer
    cyc(1, 0, 32'hE1000123, 1);
    chk("e1_first", pkt_first, 1);
    chk("e1_last", pkt_last, 1);
    chk("e1_op", pkt_opcode, 8'hE1);
    cyc(0, 0, 0, 1);
    chk("e1_busy", busy, 0);

    gen_pkt(8'h38);
    run_stim(0);

    sq = '{32'hA0000000, 32'h00100010, 32'h00020003, 32'h1, 32'h2, 32'h3};
    run_stim(1);
    sq = '{32'hA0000000, 32'h0, 32'h00010000};
    repeat (512) sq.push_back($urandom);
    run_stim(1);
    sq = '{32'hA1000000, 32'h0, 32'h00000001};
    repeat (256) sq.push_back($urandom);
    run_stim(1);

    sq = '{32'h48000000, 32'h00100010, 32'h50005000, 32'h00300030, 32'h55555555};
    run_stim(1);
    sq = '{32'h58000000, 32'h00100010, 32'h00FF00FF, 32'h50005000, 32'h55555555};
    run_stim(1);

    // fill with a stalled consumer, then force writes at full
    for (int i = 0; i < 16; i++) cyc(1, 0, {8'hE1, 24'($urandom)}, 0);
    chk("full_flag", fifo_full, 1);
    chk("full_ovf", overflow, 0);
    cyc(1, 0, 32'hE1ABCDEF, 0);
    chk("ovf_set", overflow, 1);
    chk("ovf_cnt", fifo_count, 16);
    cyc(1, 0, 32'hE1000000, 1);
    chk("full_pushpop_cnt", fifo_count, 15);
    run_stim(1);

    // GP1 reset mid-packet with a colliding GP0 write
    cyc(1, 0, 32'h38000000, 1);
    cyc(1, 0, 32'h1, 1);
    cyc(1, 0, 32'h2, 1);
    cyc(1, 1, 32'h01000000, 1);
    chk("flush_g1v", gp1_valid, 1);
    chk("flush_cnt", fifo_count, 0);
    chk("flush_ovf", overflow, 0);
    chk("flush_busy", busy, 0);
    cyc(1, 0, 32'hE2000001, 1);
    chk("flush_first", pkt_first, 1);
    cyc(0, 0, 0, 1);
    cyc(1, 1, 32'h05000000, 0);
    chk("collide_ovf", overflow, 1);
    cyc(0, 1, 32'h00000000, 0);
    chk("clear_ovf", overflow, 0);

    // async reset in the middle of a packet
    cyc(1, 0, 32'h38000000, 1);
    cyc(1, 0, 32'h3, 1);
    cyc(1, 0, 32'h4, 0);
    do_reset();
    cyc(1, 0, 32'hE3000000, 1);
    cyc(0, 0, 0, 1);

    repeat (60) begin
      gen_pkt(8'($urandom));
      run_stim(1);
      if ($urandom_range(0, 5) == 0) cyc(0, 1, {8'($urandom_range(0, 3)), 24'($urandom)}, 1);
    end
    cyc(0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
